// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dma_ctrl
//  Purpose  : Memory-to-memory block-copy DMA engine that shares the single
//             external address/data bus with the CPU core. The core is stalled
//             through its RDY line. The engine then alternates read and write
//             bus cycles until the block is copied, and hands the bus back.
//  Revision : 1.0  initial release
//
//  Ports
//    ph2          in   sole clock, rising edge
//    reset        in   synchronous, active-low reset
//    start        in   one-cycle copy request (ignored while busy)
//    src/dst      in   16-bit source / destination start addresses
//    len          in   LEN_W-bit byte count (0 = no bus cycles, just done)
//    cpu_address  in   core address bus
//    cpu_data_out in   core write data
//    cpu_read_en  in   core read (1) / write (0) cycle
//    cpu_rdy      out  0 stalls the core on its next read cycle
//    cpu_data_in  out  read data to the core (bus_data_in)
//    bus_address  out  external address bus
//    bus_data_out out  external write data
//    bus_read_en  out  external read enable, 0 = write cycle
//    bus_data_in  in   external read data
//    busy         out  copy in progress (STALL/READ/WRITE)
//    done         out  one-cycle completion pulse
//
//  Build option
//    DMA_BURST_LIMIT_EN : cycle-stealing mode. After every BURST bytes the
//                         core gets one cycle with RDY high before the engine
//                         re-stalls it.
// ============================================================================
module dma_ctrl #(
   parameter int LEN_W = 8,
   parameter int BURST = 4
) (
   input  logic             ph2,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      src,
   input  logic [15:0]      dst,
   input  logic [LEN_W-1:0] len,
   input  logic [15:0]      cpu_address,
   input  logic [7:0]       cpu_data_out,
   input  logic             cpu_read_en,
   output logic             cpu_rdy,
   output logic [7:0]       cpu_data_in,
   output logic [15:0]      bus_address,
   output logic [7:0]       bus_data_out,
   output logic             bus_read_en,
   input  logic [7:0]       bus_data_in,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STALL = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state, next_state;
   logic [15:0]       src_ptr, dst_ptr;
   logic [LEN_W-1:0]  cnt;
   logic [7:0]        data_reg;

   // burst_end : the WRITE now on the bus closes a burst
   // grant_hold: the current STALL cycle belongs to the core (RDY high)
   logic              burst_end;
   logic              grant_hold;

`ifdef DMA_BURST_LIMIT_EN
   localparam int BC_W = $clog2(BURST + 1);

   logic [BC_W-1:0]   burst_cnt;
   logic              grant;

   assign burst_end  = (burst_cnt == BC_W'(BURST - 1));
   assign grant_hold = grant;

   // grant is raised only on the edge that re-enters STALL mid-copy, so it
   // is high for exactly that one STALL cycle.
   always_ff @(posedge ph2) begin
      if (!reset) begin
         burst_cnt <= '0;
         grant     <= 1'b0;
      end else begin
         grant <= 1'b0;
         if (state == S_IDLE) begin
            burst_cnt <= '0;
         end else if (state == S_WRITE && cnt != LEN_W'(1)) begin
            if (burst_end) begin
               burst_cnt <= '0;
               grant     <= 1'b1;
            end else begin
               burst_cnt <= burst_cnt + BC_W'(1);
            end
         end
      end
   end
`else
   logic unused_burst;

   assign burst_end    = 1'b0;
   assign grant_hold   = 1'b0;
   assign unused_burst = (BURST != 0);
`endif

   // ---------------------------------------------------------------------
   // State register and datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge ph2) begin
      if (!reset) begin
         state    <= S_IDLE;
         src_ptr  <= '0;
         dst_ptr  <= '0;
         cnt      <= '0;
         data_reg <= '0;
      end else begin
         state <= next_state;
         case (state)
            S_IDLE: begin
               if (start && len != '0) begin
                  src_ptr <= src;
                  dst_ptr <= dst;
                  cnt     <= len;
               end
            end
            S_READ: begin
               data_reg <= bus_data_in;
               src_ptr  <= src_ptr + 16'd1;
            end
            S_WRITE: begin
               dst_ptr <= dst_ptr + 16'd1;
               cnt     <= cnt - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Next state, handshake outputs and bus mux
   // ---------------------------------------------------------------------
   always_comb begin
      next_state   = state;
      cpu_rdy      = 1'b1;
      busy         = 1'b0;
      done         = 1'b0;
      bus_address  = cpu_address;
      bus_data_out = cpu_data_out;
      bus_read_en  = cpu_read_en;

      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (len == '0) ? S_DONE : S_STALL;
            end
         end
         S_STALL: begin
            busy    = 1'b1;
            cpu_rdy = grant_hold;
            // The core only freezes on a read cycle, so the bus is safe to
            // take once a read is seen while RDY is low.
            if (!grant_hold && cpu_read_en) begin
               next_state = S_READ;
            end
         end
         S_READ: begin
            busy        = 1'b1;
            cpu_rdy     = 1'b0;
            bus_address = src_ptr;
            bus_read_en = 1'b1;
            next_state  = S_WRITE;
         end
         S_WRITE: begin
            busy         = 1'b1;
            cpu_rdy      = 1'b0;
            bus_address  = dst_ptr;
            bus_read_en  = 1'b0;
            bus_data_out = data_reg;
            if (cnt == LEN_W'(1)) begin
               next_state = S_DONE;
            end else if (burst_end) begin
               next_state = S_STALL;
            end else begin
               next_state = S_READ;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   assign cpu_data_in = bus_data_in;

endmodule
`default_nettype wire
